// File: rtl/wb_stage_if.sv
// Signal bundle between the MEM/WB pipe, decode read ports, EX forwarding and the writeback stage.
interface wb_stage_if;
  logic        valid_i;
  logic        RF_WE_i;
  logic        WBSelect_i;
  logic [31:0] AluResult_i;
  logic [31:0] ReadData_i;
  logic [3:0]  A3_i;
  logic [31:0] PC8_i;
  logic [3:0]  A1_i;
  logic [3:0]  A2_i;
  logic [31:0] RD1_o;
  logic [31:0] RD2_o;
  logic [3:0]  RA_ex_i;
  logic [3:0]  RB_ex_i;
  logic [3:0]  A3_mem_i;
  logic        RF_WE_mem_i;
  logic [1:0]  ForwardA_o;
  logic [1:0]  ForwardB_o;
  logic [31:0] WBResult_o;
  logic [31:0] retired_o;

  modport master (
    output valid_i, RF_WE_i, WBSelect_i, AluResult_i, ReadData_i, A3_i, PC8_i,
    output A1_i, A2_i, RA_ex_i, RB_ex_i, A3_mem_i, RF_WE_mem_i,
    input  RD1_o, RD2_o, ForwardA_o, ForwardB_o, WBResult_o, retired_o
  );

  modport slave (
    input  valid_i, RF_WE_i, WBSelect_i, AluResult_i, ReadData_i, A3_i, PC8_i,
    input  A1_i, A2_i, RA_ex_i, RB_ex_i, A3_mem_i, RF_WE_mem_i,
    output RD1_o, RD2_o, ForwardA_o, ForwardB_o, WBResult_o, retired_o
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: result select, 15-entry register file with write-through reads,
// EX operand forwarding selects and a retired-instruction counter.
module wb_stage (
  input  logic       CLK,
  input  logic       RST,
  wb_stage_if.slave  bus
);

  logic [31:0] r_rf [0:14];
  logic [31:0] r_retired;
  logic [31:0] w_result;
  logic        w_wr_en;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  assign w_result = bus.WBSelect_i ? bus.ReadData_i : bus.AluResult_i;
  // R15 is the PC, never a storage target.
  assign w_wr_en  = bus.valid_i & bus.RF_WE_i & (bus.A3_i != 4'd15);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 15; i++) r_rf[i] <= '0;
      r_retired <= '0;
    end else begin
      if (w_wr_en) r_rf[bus.A3_i] <= w_result;
      if (bus.valid_i) r_retired <= r_retired + 32'd1;
    end
  end

  always_comb begin
    w_rd1 = '0;
    if (bus.A1_i == 4'd15)                     w_rd1 = bus.PC8_i;
    else if (w_wr_en && bus.A1_i == bus.A3_i)  w_rd1 = w_result;
    else                                       w_rd1 = r_rf[bus.A1_i];
  end

  always_comb begin
    w_rd2 = '0;
    if (bus.A2_i == 4'd15)                     w_rd2 = bus.PC8_i;
    else if (w_wr_en && bus.A2_i == bus.A3_i)  w_rd2 = w_result;
    else                                       w_rd2 = r_rf[bus.A2_i];
  end

  // The younger EX/MEM producer wins over MEM/WB; 2'b11 is unreachable.
  always_comb begin
    w_fwd_a = 2'b00;
    if (bus.RA_ex_i != 4'd15) begin
      if (bus.RF_WE_mem_i && bus.A3_mem_i == bus.RA_ex_i)                   w_fwd_a = 2'b10;
      else if (bus.valid_i && bus.RF_WE_i && bus.A3_i == bus.RA_ex_i)       w_fwd_a = 2'b01;
    end
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (bus.RB_ex_i != 4'd15) begin
      if (bus.RF_WE_mem_i && bus.A3_mem_i == bus.RB_ex_i)                   w_fwd_b = 2'b10;
      else if (bus.valid_i && bus.RF_WE_i && bus.A3_i == bus.RB_ex_i)       w_fwd_b = 2'b01;
    end
  end

  assign bus.WBResult_o = w_result;
  assign bus.RD1_o      = w_rd1;
  assign bus.RD2_o      = w_rd2;
  assign bus.ForwardA_o = w_fwd_a;
  assign bus.ForwardB_o = w_fwd_b;
  assign bus.retired_o  = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: vector table through a scoreboard queue, then hand sequences
// for forwarding priority, reset behaviour and counter wrap.
module tb_wb_stage;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  wb_stage_if bus ();

  wb_stage dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        valid;
    logic        we;
    logic        sel;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [3:0]  a3;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [31:0] pc8;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_wb;
  } vec_t;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wb;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.valid_i = 0; bus.RF_WE_i = 0; bus.WBSelect_i = 0;
    bus.AluResult_i = '0; bus.ReadData_i = '0; bus.A3_i = '0; bus.PC8_i = '0;
    bus.A1_i = '0; bus.A2_i = '0; bus.RA_ex_i = '0; bus.RB_ex_i = '0;
    bus.A3_mem_i = '0; bus.RF_WE_mem_i = 0;
  endtask

  initial begin
    exp_t e;
    // valid we sel alu rdata a3 a1 a2 pc8 | rd1 rd2 wb
    vecs[0] = '{1,1,0,32'h1234,32'h0,3,0,0,32'h100, 32'h0,32'h0,32'h1234};
    vecs[1] = '{1,1,1,32'h0,32'hBEEF,4,3,1,32'h100, 32'h1234,32'h0,32'hBEEF};
    vecs[2] = '{0,1,0,32'h77,32'h0,4,4,4,32'h100, 32'hBEEF,32'hBEEF,32'h77};
    vecs[3] = '{1,1,0,32'hAA,32'h0,5,5,5,32'h100, 32'hAA,32'hAA,32'hAA};
    vecs[4] = '{1,1,0,32'h55,32'h0,15,15,5,32'h108, 32'h108,32'hAA,32'h55};
    vecs[5] = '{1,0,0,32'h99,32'h0,6,6,15,32'h200, 32'h0,32'h200,32'h99};
    vecs[6] = '{0,0,0,32'h0,32'h0,0,6,3,32'h0, 32'h0,32'h1234,32'h0};
    vecs[7] = '{1,1,1,32'h0,32'hDEAD0001,0,14,0,32'h0, 32'h0,32'hDEAD0001,32'hDEAD0001};
    vecs[8] = '{1,1,0,32'h0E0E,32'h0,14,0,14,32'h0, 32'hDEAD0001,32'h0E0E,32'h0E0E};

    idle_inputs();
    #12;
    check("reset_retired", bus.retired_o, 32'h0);
    RST = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      bus.valid_i = vecs[i].valid; bus.RF_WE_i = vecs[i].we; bus.WBSelect_i = vecs[i].sel;
      bus.AluResult_i = vecs[i].alu; bus.ReadData_i = vecs[i].rdata; bus.A3_i = vecs[i].a3;
      bus.A1_i = vecs[i].a1; bus.A2_i = vecs[i].a2; bus.PC8_i = vecs[i].pc8;
      sb.push_back('{vecs[i].exp_rd1, vecs[i].exp_rd2, vecs[i].exp_wb});
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d_rd1", i), bus.RD1_o, e.rd1);
      check($sformatf("vec%0d_rd2", i), bus.RD2_o, e.rd2);
      check($sformatf("vec%0d_wb", i), bus.WBResult_o, e.wb);
    end
    @(negedge CLK);
    idle_inputs();
    #1 check("retired_after_table", bus.retired_o, 32'd7);

    // forwarding priority
    bus.RA_ex_i = 2; bus.RB_ex_i = 2; bus.A3_mem_i = 2; bus.RF_WE_mem_i = 1;
    bus.valid_i = 1; bus.RF_WE_i = 1; bus.A3_i = 2;
    #1 check("fwdA_mem", {30'd0, bus.ForwardA_o}, 32'd2);
    check("fwdB_mem", {30'd0, bus.ForwardB_o}, 32'd2);
    bus.RF_WE_mem_i = 0;
    #1 check("fwdA_wb", {30'd0, bus.ForwardA_o}, 32'd1);
    check("fwdB_wb", {30'd0, bus.ForwardB_o}, 32'd1);
    bus.RA_ex_i = 15; bus.A3_mem_i = 15; bus.A3_i = 15; bus.RF_WE_mem_i = 1;
    #1 check("fwdA_r15", {30'd0, bus.ForwardA_o}, 32'd0);
    bus.RB_ex_i = 7; bus.A3_mem_i = 7; bus.valid_i = 0;
    #1 check("fwdB_mem_only", {30'd0, bus.ForwardB_o}, 32'd2);
    bus.RF_WE_mem_i = 0; bus.A3_i = 7; bus.RF_WE_i = 1;
    #1 check("fwdB_wb_invalid", {30'd0, bus.ForwardB_o}, 32'd0);
    bus.valid_i = 1; bus.RF_WE_i = 0;
    #1 check("fwdB_wb_nowe", {30'd0, bus.ForwardB_o}, 32'd0);

    // reset mid-cycle with a pending write; R7 must stay 0
    @(negedge CLK);
    idle_inputs();
    bus.valid_i = 1; bus.RF_WE_i = 1; bus.A3_i = 7; bus.AluResult_i = 32'h77;
    #2 RST = 1'b0;
    #1 check("reset_async_retired", bus.retired_o, 32'h0);
    @(negedge CLK);
    check("reset_hold_retired", bus.retired_o, 32'h0);
    bus.AluResult_i = 32'h31;
    #1 check("reset_wb_follows", bus.WBResult_o, 32'h31);
    bus.valid_i = 0; bus.RF_WE_i = 0;
    for (int i = 0; i < 15; i++) begin
      bus.A1_i = 4'(i); bus.A2_i = 4'(14 - i);
      #1 check($sformatf("reset_r%0d", i), bus.RD1_o, 32'h0);
    end
    check("reset_rd2_r0", bus.RD2_o, 32'h0);

    @(negedge CLK);
    RST = 1'b1;
    bus.valid_i = 1; bus.RF_WE_i = 1; bus.A3_i = 7; bus.AluResult_i = 32'h77;
    @(negedge CLK);
    idle_inputs();
    bus.A1_i = 7;
    #1 check("resume_r7", bus.RD1_o, 32'h77);
    check("resume_retired", bus.retired_o, 32'd1);

    // counter wrap
    force dut.r_retired = 32'hFFFFFFFE;
    #1 release dut.r_retired;
    #1 check("wrap_preload", bus.retired_o, 32'hFFFFFFFE);
    bus.valid_i = 1;
    @(negedge CLK);
    check("wrap_ffff", bus.retired_o, 32'hFFFFFFFF);
    @(negedge CLK);
    check("wrap_zero", bus.retired_o, 32'h0);
    bus.valid_i = 0;
    @(negedge CLK);
    check("wrap_invalid_hold", bus.retired_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: RST  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: valid_i  input  1  the MEM/WB pipe output holds a live instruction.
REQ-004 SHALL have port: RF_WE_i  input  1  register-file write enable from MEM/WB.
REQ-005 SHALL have port: WBSelect_i  input  1  result select: 1 = ReadData_i, 0 = AluResult_i.
REQ-006 SHALL have ports: AluResult_i and ReadData_i  input  32 each  candidate writeback values.
REQ-007 SHALL have port: A3_i  input  4  destination register.
REQ-008 SHALL have port: PC8_i  input  32  PC+8 value returned for reads of R15.
REQ-009 SHALL have ports: A1_i and A2_i  input  4 each  decode-stage read addresses.
REQ-010 SHALL have ports: RD1_o and RD2_o  output  32 each  read data.
REQ-011 SHALL have ports: RA_ex_i and RB_ex_i  input  4 each  EX-stage source operands.
REQ-012 SHALL have ports: A3_mem_i  input  4, and RF_WE_mem_i  input  1  EX/MEM destination and write enable.
REQ-013 SHALL have ports: ForwardA_o and ForwardB_o  output  2 each  EX operand forwarding selects.
REQ-014 SHALL have port: WBResult_o  output  32  selected writeback value.
REQ-015 SHALL have port: retired_o  output  32  count of retired valid instructions.

Function
REQ-016 SHALL compute WBResult_o combinationally as ReadData_i when WBSelect_i=1, else AluResult_i.
REQ-017 SHALL hold 15 x 32-bit registers R0-R14; R15 is not stored.
REQ-018 SHALL write WBResult_o into R[A3_i] on the rising CLK edge when valid_i=1, RF_WE_i=1 and A3_i!=15.
REQ-019 SHALL ignore a write to A3_i=15: no state change, no error.
REQ-020 SHALL drive RD1_o and RD2_o combinationally: PC8_i when the address is 15; else WBResult_o when the address matches A3_i with a qualifying write in the same cycle (write-through); else R[addr].
REQ-021 SHALL apply write-through to both read ports independently when A1_i=A2_i=A3_i.
REQ-022 SHALL set ForwardA_o=2'b10 when RF_WE_mem_i=1, A3_mem_i=RA_ex_i and RA_ex_i!=15.
REQ-023 SHALL otherwise set ForwardA_o=2'b01 when valid_i=1, RF_WE_i=1, A3_i=RA_ex_i and RA_ex_i!=15.
REQ-024 SHALL otherwise set ForwardA_o=2'b00; the MEM match takes priority when MEM and WB both match.
REQ-025 SHALL apply REQ-022 to REQ-024 identically to ForwardB_o using RB_ex_i.
REQ-026 SHALL never produce the value 2'b11 on ForwardA_o or ForwardB_o.
REQ-027 SHALL increment retired_o by 1 on each rising edge with valid_i=1, regardless of RF_WE_i.
REQ-028 SHALL wrap retired_o from 0xFFFFFFFF to 0.
REQ-029 SHALL have a one-cycle latency from write to architectural state: a read in the following cycle returns the stored value.

Reset
REQ-030 SHALL clear R0-R14 and retired_o to 0 immediately when RST=0, independent of CLK.
REQ-031 SHALL block writes and counting while RST=0; combinational outputs SHALL still follow their inputs.
REQ-032 SHALL discard any write pending when reset is asserted mid-cycle.
REQ-033 SHALL resume normal operation at the first rising edge after RST returns to 1.

Verification
REQ-034 SHALL cover reset: drive RST=0 after writes, then read R0-R14 -> every read returns 0 and retired_o=0.
REQ-035 SHALL cover write then read: write AluResult_i=0x1234, WBSelect_i=0, A3_i=3; next cycle A1_i=3 -> RD1_o=0x1234. Repeat with WBSelect_i=1, ReadData_i=0xBEEF, A3_i=4, A2_i=4 -> RD2_o=0xBEEF.
REQ-036 SHALL cover write-through: in the same cycle, A3_i=5, WBResult=0xAA, A1_i=A2_i=5 -> RD1_o=RD2_o=0xAA before the edge.
REQ-037 SHALL cover R15: write 0x55 to A3_i=15, then read with A1_i=15 and PC8_i=0x108 -> RD1_o=0x108; no register changes.
REQ-038 SHALL cover forwarding priority: RA_ex_i=2, A3_mem_i=2, RF_WE_mem_i=1, and a valid WB write to 2 -> ForwardA_o=10. With RF_WE_mem_i=0 -> 01. With RA_ex_i=15 -> 00.
REQ-039 SHALL cover counter wrap: preload retired_o to 0xFFFFFFFE via 0xFFFFFFFE valid cycles or a force, then apply 2 valid cycles -> retired_o=0. An invalid cycle -> no change.
